seed_serial_word_buf: RTL and testbench

- Parametrised lane-serial word buffer for the serialized SEED datapath.
- Collects LANES lanes of LANE_W bits into one word through a valid/ready input handshake, then presents the word in parallel and drains it lane-by-lane through a valid/ready output handshake.
- Sits between the 8-bit round-function stages (F/G computation) and the next serial consumer.
- Adds the following over a fixed 32-bit store: a fill counter, back-pressure on both sides, full/empty status, flush, and a drain-order option.

---
 rtl/seed_serial_word_buf.sv | 118 +++++++++++
 tb/tb_seed_serial_word_buf.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seed_serial_word_buf.sv
// Lane-serial word buffer for the serialized SEED datapath.
// Optional parallel load port enabled by SEED_SERIAL_BUF_PARLOAD_EN.
`timescale 1ns/1ps
module seed_serial_word_buf #(
  parameter int LANE_W      = 8,
  parameter int LANES       = 4,
  parameter bit OUT_REVERSE = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
`ifdef SEED_SERIAL_BUF_PARLOAD_EN
  input  logic                      par_load,
  input  logic [LANE_W*LANES-1:0]   par_data,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANE_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANE_W-1:0]         out_data,
  output logic [LANE_W*LANES-1:0]   word_out,
  output logic                      word_valid,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(LANES+1)-1:0] count
);

  localparam int W  = LANE_W * LANES;
  localparam int CW = $clog2(LANES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(LANES);

  typedef enum logic {
    FILL,
    DRAIN
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   sreg, sreg_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           load;
  logic [W-1:0]   load_data;

`ifdef SEED_SERIAL_BUF_PARLOAD_EN
  assign load      = par_load;
  assign load_data = par_data;
`else
  assign load      = 1'b0;
  assign load_data = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    cnt_n     = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    unique case (state)
      FILL: begin
        in_ready = !load;
        if (load) begin
          sreg_n  = load_data;
          cnt_n   = FULL_CNT;
          state_n = DRAIN;
        end else if (in_valid) begin
          sreg_n = {in_data, sreg[W-1:LANE_W]};
          cnt_n  = cnt + CW'(1);
          if (cnt_n == FULL_CNT) state_n = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (OUT_REVERSE) begin
          // newest lane sits at index count-1; zero it once taken
          for (int i = 0; i < LANES; i++) begin
            if (CW'(i) == cnt - CW'(1)) begin
              out_data = sreg[i*LANE_W +: LANE_W];
              if (out_ready) sreg_n[i*LANE_W +: LANE_W] = '0;
            end
          end
        end else begin
          out_data = sreg[LANE_W-1:0];
          if (out_ready) sreg_n = {{LANE_W{1'b0}}, sreg[W-1:LANE_W]};
        end
        if (out_ready) begin
          cnt_n = cnt - CW'(1);
          if (cnt_n == '0) state_n = FILL;
        end
      end
      default: state_n = FILL;
    endcase
    if (flush) begin
      sreg_n  = '0;
      cnt_n   = '0;
      state_n = FILL;
    end
  end

  assign word_out   = sreg;
  assign word_valid = (state == DRAIN) && (cnt == FULL_CNT);
  assign full       = word_valid;
  assign empty      = (state == FILL) && (cnt == '0);
  assign count      = cnt;

endmodule

// File: tb/tb_seed_serial_word_buf.sv
// Scoreboard bench: both drain orders driven in lockstep against a lane-list model.
// Exercises par_load paths when SEED_SERIAL_BUF_PARLOAD_EN is defined.
`timescale 1ns/1ps
module tb_seed_serial_word_buf;

  localparam int LN = 4;

`ifdef SEED_SERIAL_BUF_PARLOAD_EN
  localparam bit PL_EN = 1'b1;
`else
  localparam bit PL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        par_load = 1'b0;
  logic [7:0]  in_data = '0;
  logic [31:0] par_data = '0;

  logic        in_ready_f, out_valid_f, word_valid_f, full_f, empty_f;
  logic [7:0]  out_data_f;
  logic [31:0] word_out_f;
  logic [2:0]  count_f;
  logic        in_ready_r, out_valid_r, word_valid_r, full_r, empty_r;
  logic [7:0]  out_data_r;
  logic [31:0] word_out_r;
  logic [2:0]  count_r;

  int checks = 0;
  int errors = 0;

  logic [7:0]  lanes[$];
  logic [7:0]  fwd_q[$];
  logic [7:0]  rev_q[$];
  int          rem = 0;
  bit          draining = 1'b0;
  logic [31:0] full_word = '0;

  always #5 clk = ~clk;

  seed_serial_word_buf #(.LANE_W(8), .LANES(LN), .OUT_REVERSE(1'b0)) dut_f (
    .clk(clk), .reset_n(reset_n), .flush(flush),
`ifdef SEED_SERIAL_BUF_PARLOAD_EN
    .par_load(par_load), .par_data(par_data),
`endif
    .in_valid(in_valid), .in_ready(in_ready_f), .in_data(in_data),
    .out_valid(out_valid_f), .out_ready(out_ready), .out_data(out_data_f),
    .word_out(word_out_f), .word_valid(word_valid_f), .full(full_f),
    .empty(empty_f), .count(count_f)
  );

  seed_serial_word_buf #(.LANE_W(8), .LANES(LN), .OUT_REVERSE(1'b1)) dut_r (
    .clk(clk), .reset_n(reset_n), .flush(flush),
`ifdef SEED_SERIAL_BUF_PARLOAD_EN
    .par_load(par_load), .par_data(par_data),
`endif
    .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
    .word_out(word_out_r), .word_valid(word_valid_r), .full(full_r),
    .empty(empty_r), .count(count_r)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    lanes.delete();
    fwd_q.delete();
    rev_q.delete();
    draining = 1'b0;
    rem = 0;
  endtask

  task automatic complete_word(input logic [7:0] w[$]);
    full_word = '0;
    fwd_q.delete();
    rev_q.delete();
    for (int j = 0; j < LN; j++) begin
      full_word[j*8 +: 8] = w[j];
      fwd_q.push_back(w[j]);
      rev_q.push_front(w[j]);
    end
    lanes.delete();
    draining = 1'b1;
    rem = LN;
  endtask

  task automatic model_update();
    logic [7:0] pw[$];
    if (flush) begin
      model_reset();
    end else if (!draining && PL_EN && par_load) begin
      for (int j = 0; j < LN; j++) pw.push_back(par_data[j*8 +: 8]);
      complete_word(pw);
    end else if (!draining && in_valid) begin
      lanes.push_back(in_data);
      if (lanes.size() == LN) complete_word(lanes);
    end else if (draining && out_ready) begin
      rem--;
      if (rem == 0) draining = 1'b0;
    end
  endtask

  task automatic status_one(input string t, input bit rev, input logic ir,
                            input logic ov, input logic [7:0] od,
                            input logic [31:0] wo, input logic wv,
                            input logic fu, input logic em,
                            input logic [2:0] cn);
    logic [31:0] wexp;
    int k;
    bit fullw;
    k = lanes.size();
    fullw = draining && (rem == LN);
    chk({t, "_in_ready"}, 32'(ir), 32'(!draining && !(PL_EN && par_load)));
    chk({t, "_out_valid"}, 32'(ov), 32'(draining));
    chk({t, "_count"}, 32'(cn), draining ? 32'(rem) : 32'(k));
    chk({t, "_word_valid"}, 32'(wv), 32'(fullw));
    chk({t, "_full"}, 32'(fu), 32'(fullw));
    chk({t, "_empty"}, 32'(em), 32'(!draining && k == 0));
    if (!draining) begin
      wexp = '0;
      for (int j = 0; j < k; j++) wexp[(LN-k+j)*8 +: 8] = lanes[j];
      chk({t, "_word_fill"}, wo, wexp);
      chk({t, "_out_data_idle"}, 32'(od), 32'h0);
    end else if (fullw) begin
      chk({t, "_word_full"}, wo, full_word);
    end
    if (draining && !out_ready) begin
      if (rev && rev_q.size() > 0)
        chk({t, "_out_data_held"}, 32'(od), 32'(rev_q[0]));
      else if (!rev && fwd_q.size() > 0)
        chk({t, "_out_data_held"}, 32'(od), 32'(fwd_q[0]));
    end
  endtask

  task automatic reset_values(input string t, input logic ir,
                              input logic ov, input logic [7:0] od,
                              input logic [31:0] wo, input logic wv,
                              input logic fu, input logic em,
                              input logic [2:0] cn);
    chk({t, "_rst_in_ready"}, 32'(ir), 32'h1);
    chk({t, "_rst_out_valid"}, 32'(ov), 32'h0);
    chk({t, "_rst_out_data"}, 32'(od), 32'h0);
    chk({t, "_rst_word"}, wo, 32'h0);
    chk({t, "_rst_word_valid"}, 32'(wv), 32'h0);
    chk({t, "_rst_full"}, 32'(fu), 32'h0);
    chk({t, "_rst_empty"}, 32'(em), 32'h1);
    chk({t, "_rst_count"}, 32'(cn), 32'h0);
  endtask

  task automatic check_reset();
    reset_values("f", in_ready_f, out_valid_f, out_data_f, word_out_f,
                 word_valid_f, full_f, empty_f, count_f);
    reset_values("r", in_ready_r, out_valid_r, out_data_r, word_out_r,
                 word_valid_r, full_r, empty_r, count_r);
  endtask

  task automatic step(input logic iv, input logic [7:0] d, input logic ordy,
                      input logic fl, input logic pl, input logic [31:0] pd);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    par_load  = pl;
    par_data  = pd;
    @(negedge clk);
    status_one("f", 1'b0, in_ready_f, out_valid_f, out_data_f, word_out_f,
               word_valid_f, full_f, empty_f, count_f);
    status_one("r", 1'b1, in_ready_r, out_valid_r, out_data_r, word_out_r,
               word_valid_r, full_r, empty_r, count_r);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic fill4(input logic [31:0] w);
    for (int j = 0; j < LN; j++) step(1'b1, w[j*8 +: 8], 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 8'h0, ordy, 1'b0, 1'b0, '0);
  endtask

  // Monitor: every drain handshake pops the next expected lane.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && !flush && out_ready) begin
        if (out_valid_f) begin
          if (fwd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL drain_f extra lane got %0h want none", out_data_f);
          end else begin
            e = fwd_q.pop_front();
            chk("drain_f", 32'(out_data_f), 32'(e));
          end
        end
        if (out_valid_r) begin
          if (rev_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL drain_r extra lane got %0h want none", out_data_r);
          end else begin
            e = rev_q.pop_front();
            chk("drain_r", 32'(out_data_r), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    #3;
    check_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    fill4(32'h44332211);
    chk("t1_word", word_out_f, 32'h44332211);
    chk("t1_count", 32'(count_f), 32'd4);
    chk("t1_in_ready", 32'(in_ready_f), 32'd0);
    repeat (LN) idle(1'b1);
    chk("t2_empty", 32'(empty_f), 32'd1);
    chk("t2_in_ready", 32'(in_ready_r), 32'd1);

    fill4(32'h44332211);
    for (int i = 0; i < 2 * LN; i++) idle(i % 2 == 0);

    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0, '0);
    chk("t4_count", 32'(count_f), 32'd0);
    chk("t4_empty", 32'(empty_r), 32'd1);
    chk("t4_word", word_out_f, 32'h0);

    fill4($urandom);
    idle(1'b1);
    idle(1'b1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    fill4(32'h04030201);
    chk("t5_word", word_out_f, 32'h04030201);
    repeat (LN) idle(1'b1);

    if (PL_EN) begin
      step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
      chk("t6_word", word_out_f, 32'hDEADBEEF);
      chk("t6_count", 32'(count_f), 32'd4);
      repeat (LN) idle(1'b1);
    end

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
           $urandom_range(0, 39) == 0,
           PL_EN && ($urandom_range(0, 19) == 0), $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
